// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks a register table and issues one I2C write per entry
// Optional: define I2C_CFG_RETRY_LIMIT_EN to abort a run after MAX_RETRY+1 NACKs on one entry.
module i2c_cfg_sequencer #(
  parameter int          NUM_REGS   = 11,
  parameter logic [7:0]  DEV_ADDR   = 8'h34,
  parameter int          GAP_CYCLES = 4,
  parameter bit          AUTO_START = 1'b1,
  parameter int          MAX_RETRY  = 3,
  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             SCLK,
  input  logic             msg_end,
  input  logic             msg_ack,
  output logic [IDX_W-1:0] tbl_index,
  input  logic [15:0]      tbl_data,
  output logic             msg_go,
  output logic [23:0]      i2c_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, LAUNCH, WAIT_END, NEXT, GAP, DONE, ERROR
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  // GAP always lasts at least one cycle, so a zero gap collapses to a single pass
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] index;
  logic [RTY_W-1:0] retry;
  logic [GAP_W-1:0] gap_cnt;
  logic             auto_pend;
  logic             go_req;
  logic             nack;
  logic             is_last;
  logic             retry_full;

  // auto_pend is only high on the first cycle after reset, acting as a one-shot start
  assign go_req     = start | auto_pend;
  assign nack       = msg_end & ~msg_ack;
  assign is_last    = (index == LAST_IDX);
  assign retry_full = (retry == RTY_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_nxt = state;
    msg_go    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    tbl_index = index;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go_req) state_nxt = FETCH;
      end
      FETCH:  state_nxt = LOAD;
      LOAD:   state_nxt = LAUNCH;
      LAUNCH: if (SCLK) state_nxt = WAIT_END;
      WAIT_END: begin
        msg_go = 1'b1;
        if (msg_end) begin
          if (msg_ack) begin
            state_nxt = NEXT;
          end else begin
`ifdef I2C_CFG_RETRY_LIMIT_EN
            state_nxt = retry_full ? ERROR : LAUNCH;
`else
            state_nxt = LAUNCH;
`endif
          end
        end
      end
      NEXT: state_nxt = is_last ? DONE : GAP;
      GAP:  if (gap_cnt == GAP_LAST) state_nxt = FETCH;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = FETCH;
      end
      ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table index, retry/gap counters and the captured message word
  always_ff @(posedge clk) begin
    if (reset) begin
      index     <= '0;
      retry     <= '0;
      gap_cnt   <= '0;
      i2c_data  <= '0;
      auto_pend <= AUTO_START;
    end else begin
      auto_pend <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (go_req) begin
            index <= '0;
            retry <= '0;
          end
        end
        LOAD: i2c_data <= {DEV_ADDR, tbl_data};
        WAIT_END: begin
          // saturates so the unlimited-retry build never wraps the count
          if (nack && !retry_full) retry <= retry + 1'b1;
        end
        NEXT: begin
          gap_cnt <= '0;
          if (!is_last) begin
            index <= index + 1'b1;
            retry <= '0;
          end
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
